// File: rtl/spi_resp.sv
// SPI responder: 16-bit frames (R/W, 7-bit address, 8-bit data) sampled from an asynchronous
// monarch via synchronisers; writes surface as a wr_vld pulse, reads fetch rd_data after the command byte.
module spi_resp #(
    parameter logic [7:0] WHO_AM_I = 8'h6A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SS_n,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [7:0] rd_data,
    output logic [6:0] rd_addr,
    output logic       rd_strb,
    output logic       wr_vld,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frm_err
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, OVR} state_t;

    state_t      state, state_nxt;
    logic        ss_s1, ss_s2, ss_s3;
    logic        sclk_s1, sclk_s2, sclk_s3;
    logic        mosi_s1, mosi_s2;
    logic        ss_rise, ss_fall, sclk_rise, sclk_fall;
    logic [4:0]  cnt;
    logic [15:0] rx;
    logic [15:0] rx_nxt;
    logic [7:0]  tx;
    logic        frame_start, frame_end, do_rise, do_shift;

    // SS_n flops reset low so a select already held low at reset never looks like a fresh fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_s1   <= 1'b0;
            ss_s2   <= 1'b0;
            ss_s3   <= 1'b0;
            sclk_s1 <= 1'b1;
            sclk_s2 <= 1'b1;
            sclk_s3 <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            ss_s1   <= SS_n;
            ss_s2   <= ss_s1;
            ss_s3   <= ss_s2;
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    assign ss_rise   =  ss_s2 & ~ss_s3;
    assign ss_fall   = ~ss_s2 &  ss_s3;
    assign sclk_rise =  sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 &  sclk_s3;
    assign rx_nxt    = {rx[14:0], mosi_s2};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A select rise always takes priority over any SCLK edge seen in the same clock.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        do_rise     = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt   = CMD;
                    frame_start = 1'b1;
                end
            end
            CMD: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end else if (sclk_rise) begin
                    do_rise = 1'b1;
                    if (cnt == 5'd7) state_nxt = DATA;
                end
            end
            DATA: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end else if (sclk_rise) begin
                    do_rise = 1'b1;
                    if (cnt == 5'd16) state_nxt = OVR;
                end
            end
            OVR: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign do_shift = (state == DATA) && !ss_rise && sclk_fall &&
                      (cnt >= 5'd9) && (cnt <= 5'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 5'd0;
            rx      <= 16'h0000;
            tx      <= 8'h00;
            rd_addr <= 7'h00;
            wr_addr <= 7'h00;
            wr_data <= 8'h00;
            rd_strb <= 1'b0;
            wr_vld  <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            rd_strb <= 1'b0;
            wr_vld  <= 1'b0;
            frm_err <= 1'b0;
            if (frame_start) begin
                cnt <= 5'd0;
                rx  <= 16'h0000;
                tx  <= 8'h00;
            end else if (frame_end) begin
                tx <= 8'h00;
                if (cnt == 5'd16) begin
                    if (!rx[15]) begin
                        wr_vld  <= 1'b1;
                        wr_addr <= rx[14:8];
                        wr_data <= rx[7:0];
                    end
                end else begin
                    frm_err <= 1'b1;
                end
            end else begin
                if (do_rise) begin
                    rx  <= rx_nxt;
                    cnt <= cnt + 5'd1;
                    // Eighth rise completes the command byte; a read fetches its data next clock.
                    if (state == CMD && cnt == 5'd7 && rx_nxt[7]) begin
                        rd_strb <= 1'b1;
                        rd_addr <= rx_nxt[6:0];
                    end
                end
                if (rd_strb)       tx <= (rd_addr == 7'h0F) ? WHO_AM_I : rd_data;
                else if (do_shift) tx <= {tx[6:0], 1'b0};
            end
        end
    end

    assign MISO = tx[7];

endmodule

// File: tb/tb_spi_resp.sv
// Bench for spi_resp: a timed SPI monarch drives frames; a frame-level model predicts pulses,
// write payloads (via an expected queue) and the read byte returned on MISO.
module tb_spi_resp;

    localparam int HP = 100;   // SCLK half period in ns (10 clk)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SS_n = 1'b1;
    logic       SCLK = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [7:0] rd_data;
    logic [6:0] rd_addr;
    logic       rd_strb;
    logic       wr_vld;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frm_err;

    logic [7:0]  mem [128];
    logic [14:0] exp_q[$];
    logic [14:0] exp_w;
    int          n_vec = 0;
    int          n_err = 0;
    int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
    int          wr0, rd0, err0;
    int          obs_wr, obs_rd, obs_err;
    logic [6:0]  last_rd_addr = 7'h00;
    logic [15:0] obs_miso;

    always #5 clk = ~clk;

    assign rd_data = mem[rd_addr];

    spi_resp #(.WHO_AM_I(8'h6A)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .rd_data(rd_data), .rd_addr(rd_addr), .rd_strb(rd_strb), .wr_vld(wr_vld),
        .wr_addr(wr_addr), .wr_data(wr_data), .frm_err(frm_err)
    );

    // Pulse monitor; write payloads are checked against the expected queue in order.
    always @(negedge clk) begin
        if (wr_vld) begin
            wr_cnt++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: got addr=%h data=%h, none expected", wr_addr, wr_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({wr_addr, wr_data} !== exp_w) begin
                    n_err++;
                    $display("FAIL wr_payload: got %h/%h want %h/%h", wr_addr, wr_data, exp_w[14:8], exp_w[7:0]);
                end
            end
        end
        if (rd_strb) begin
            rd_cnt++;
            last_rd_addr = rd_addr;
        end
        if (frm_err) err_cnt++;
    end

    // Frame-level reference: what a frame of n rises carrying w must produce.
    function automatic void model(input logic [15:0] w, input int n, output int e_wr, output int e_rd,
                                  output int e_err, output logic [15:0] e_miso);
        logic [7:0] b;
        e_err  = (n != 16) ? 1 : 0;
        e_wr   = (n == 16 && !w[15]) ? 1 : 0;
        e_rd   = (n >= 8 && w[15]) ? 1 : 0;
        b      = (w[14:8] == 7'h0F) ? 8'h6A : mem[w[14:8]];
        e_miso = (w[15] && n >= 16) ? {8'h00, b} : 16'h0000;
    endfunction

    task automatic spi_frame(input logic [15:0] w, input int n, output logic [15:0] miso_bits);
        miso_bits = 16'h0000;
        #3;
        SS_n = 1'b0;
        #(HP);
        for (int i = 0; i < n; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? w[15 - i] : 1'b0;
            #(HP);
            if (i < 16) miso_bits[15 - i] = MISO;
            SCLK = 1'b1;
            #(HP);
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] w, input int n, input int settle);
        wr0 = wr_cnt; rd0 = rd_cnt; err0 = err_cnt;
        if (n == 16 && !w[15]) exp_q.push_back(w[14:0]);
        spi_frame(w, n, obs_miso);
        repeat (settle) @(posedge clk);
        obs_wr  = wr_cnt - wr0;
        obs_rd  = rd_cnt - rd0;
        obs_err = err_cnt - err0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({MISO, rd_strb, wr_vld, frm_err} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_pulses: got %b want 0000", {MISO, rd_strb, wr_vld, frm_err});
        end
        n_vec++;
        if ({rd_addr, wr_addr, wr_data} !== 22'h0) begin
            n_err++;
            $display("FAIL reset_regs: got %h want 0", {rd_addr, wr_addr, wr_data});
        end
        rst = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_write;
        run_frame(16'h0D02, 16, 10);
        n_vec++;
        if (obs_wr !== 1 || obs_err !== 0 || obs_rd !== 0) begin
            n_err++;
            $display("FAIL write_pulses: got wr=%0d rd=%0d err=%0d want 1 0 0", obs_wr, obs_rd, obs_err);
        end
        n_vec++;
        if ({wr_addr, wr_data} !== {7'h0D, 8'h02}) begin
            n_err++;
            $display("FAIL write_hold: got %h/%h want 0d/02", wr_addr, wr_data);
        end
        n_vec++;
        if (obs_miso !== 16'h0000) begin
            n_err++;
            $display("FAIL write_miso: got %h want 0000", obs_miso);
        end
    endtask

    task automatic test_read;
        mem[7'h22] = 8'hC5;
        run_frame(16'hA200, 16, 10);
        n_vec++;
        if (obs_rd !== 1 || obs_wr !== 0 || obs_err !== 0) begin
            n_err++;
            $display("FAIL read_pulses: got rd=%0d wr=%0d err=%0d want 1 0 0", obs_rd, obs_wr, obs_err);
        end
        n_vec++;
        if (last_rd_addr !== 7'h22) begin
            n_err++;
            $display("FAIL read_addr: got %h want 22", last_rd_addr);
        end
        n_vec++;
        if (obs_miso !== 16'h00C5) begin
            n_err++;
            $display("FAIL read_miso: got %h want 00c5", obs_miso);
        end
        mem[7'h0F] = 8'h00;
        run_frame(16'h8F00, 16, 10);
        n_vec++;
        if (obs_miso !== 16'h006A) begin
            n_err++;
            $display("FAIL whoami_miso: got %h want 006a", obs_miso);
        end
    endtask

    task automatic test_frame_errors;
        run_frame(16'h0D02, 12, 10);
        n_vec++;
        if (obs_err !== 1 || obs_wr !== 0) begin
            n_err++;
            $display("FAIL short_frame: got err=%0d wr=%0d want 1 0", obs_err, obs_wr);
        end
        run_frame(16'h0D02, 17, 10);
        n_vec++;
        if (obs_err !== 1 || obs_wr !== 0) begin
            n_err++;
            $display("FAIL long_frame: got err=%0d wr=%0d want 1 0", obs_err, obs_wr);
        end
        run_frame(16'h3355, 16, 10);
        n_vec++;
        if (obs_wr !== 1 || obs_err !== 0 || {wr_addr, wr_data} !== {7'h33, 8'h55}) begin
            n_err++;
            $display("FAIL recover_write: got wr=%0d err=%0d %h/%h want 1 0 33/55", obs_wr, obs_err, wr_addr, wr_data);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] w;
        w = 16'h5A3C;
        wr0 = wr_cnt; rd0 = rd_cnt; err0 = err_cnt;
        #3;
        SS_n = 1'b0;
        #(HP);
        for (int i = 0; i < 10; i++) begin
            SCLK = 1'b0;
            MOSI = w[15 - i];
            #(HP);
            SCLK = 1'b1;
            #(HP);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++;
        if ({MISO, rd_strb, wr_vld, frm_err, rd_addr, wr_addr, wr_data} !== 26'h0) begin
            n_err++;
            $display("FAIL midreset_outputs: got %h want 0", {MISO, rd_strb, wr_vld, frm_err, rd_addr, wr_addr, wr_data});
        end
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (10) @(posedge clk);
        n_vec++;
        if ((wr_cnt - wr0) !== 0 || (rd_cnt - rd0) !== 0 || (err_cnt - err0) !== 0 || MISO !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_pulses: got wr=%0d rd=%0d err=%0d miso=%b want 0 0 0 0",
                     wr_cnt - wr0, rd_cnt - rd0, err_cnt - err0, MISO);
        end
        run_frame(16'h1060, 16, 10);
        n_vec++;
        if (obs_wr !== 1 || obs_err !== 0 || {wr_addr, wr_data} !== {7'h10, 8'h60}) begin
            n_err++;
            $display("FAIL post_reset_write: got wr=%0d err=%0d %h/%h want 1 0 10/60", obs_wr, obs_err, wr_addr, wr_data);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] m1, m2;
        mem[7'h22] = 8'hC5;
        wr0 = wr_cnt; rd0 = rd_cnt; err0 = err_cnt;
        exp_q.push_back(15'h0D02);
        spi_frame(16'h0D02, 16, m1);
        repeat (2) @(posedge clk);
        spi_frame(16'hA200, 16, m2);
        repeat (10) @(posedge clk);
        n_vec++;
        if ((wr_cnt - wr0) !== 1 || (rd_cnt - rd0) !== 1 || (err_cnt - err0) !== 0) begin
            n_err++;
            $display("FAIL b2b_pulses: got wr=%0d rd=%0d err=%0d want 1 1 0", wr_cnt - wr0, rd_cnt - rd0, err_cnt - err0);
        end
        n_vec++;
        if (m1 !== 16'h0000 || m2 !== 16'h00C5 || last_rd_addr !== 7'h22) begin
            n_err++;
            $display("FAIL b2b_data: got miso %h/%h addr %h want 0000/00c5 22", m1, m2, last_rd_addr);
        end
    endtask

    task automatic test_random;
        logic [15:0] w, e_miso;
        int n, e_wr, e_rd, e_err;
        for (int k = 0; k < 40; k++) begin
            w = 16'($urandom);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
            model(w, n, e_wr, e_rd, e_err, e_miso);
            run_frame(w, n, 10);
            n_vec++;
            if (obs_wr !== e_wr || obs_rd !== e_rd || obs_err !== e_err) begin
                n_err++;
                $display("FAIL rand_pulses: frame %h n=%0d got wr=%0d rd=%0d err=%0d want %0d %0d %0d",
                         w, n, obs_wr, obs_rd, obs_err, e_wr, e_rd, e_err);
            end
            if (e_rd == 1) begin
                n_vec++;
                if (last_rd_addr !== w[14:8]) begin
                    n_err++;
                    $display("FAIL rand_rd_addr: got %h want %h", last_rd_addr, w[14:8]);
                end
            end
            if (!w[15] || n >= 16) begin
                n_vec++;
                if (obs_miso !== e_miso) begin
                    n_err++;
                    $display("FAIL rand_miso: frame %h n=%0d got %h want %h", w, n, obs_miso, e_miso);
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
        test_reset();
        test_write();
        test_read();
        test_frame_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL wr_missing: got %0d writes still pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        n_vec++;
        n_err++;
        $display("FAIL timeout: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
